// File: rtl/frame_sink.sv
// rtl/frame_sink.sv - 3-bit framebuffer with pixel write port, clear engine and 640x480 VGA scanout
//
// Ports:
//   clk          system clock (50 MHz), rising edge
//   resetn       asynchronous active-low reset
//   writeEN      pixel write strobe, one pixel per cycle
//   x_in, y_in   pixel column / row
//   c_in         pixel colour {R,G,B}
//   clear_req    request to fill the whole framebuffer with clear_color
//   clear_color  fill colour, latched when the clear is accepted
//   busy         high while a clear sweep runs
//   clear_done   one-cycle pulse in the first idle cycle after a sweep
//   drop         one-cycle pulse for each discarded write strobe
//   vga_hs       horizontal sync, active low
//   vga_vs       vertical sync, active low
//   vga_blank_n  high during the visible area
//   vga_c        scanout colour, 3'b000 outside the visible area
module frame_sink #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 240
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       writeEN,
  input  logic [8:0] x_in,
  input  logic [7:0] y_in,
  input  logic [2:0] c_in,
  input  logic       clear_req,
  input  logic [2:0] clear_color,
  output logic       busy,
  output logic       clear_done,
  output logic       drop,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [2:0] vga_c
);

  localparam int          DEPTH     = H_PIX * V_PIX;
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [16:0] LAST_ADDR = 17'(DEPTH - 1);
  localparam logic [16:0] H_MUL     = 17'(H_PIX);
  localparam logic [9:0]  H_LIM     = 10'(H_PIX);
  localparam logic [8:0]  V_LIM     = 9'(V_PIX);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [16:0] clr_addr;
  logic [2:0]  clr_color_q;

  logic        wr_ok_q;
  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic [2:0]  c_q;

  logic        in_range;
  logic        accept_wr;

  logic        mem_we;
  logic [16:0] wr_addr;
  logic [2:0]  wr_data;
  logic [16:0] rd_addr;
  logic [2:0]  rd_data;
  logic [2:0]  mem [0:DEPTH-1];

  logic        pix_en;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [8:0]  h_half;
  logic [8:0]  v_half;
  logic        in_fb;
  logic        hs_s1;
  logic        vs_s1;
  logic        blank_s1;
  logic        fb_s1;

  // ---------------------------------------------------------------------
  // Write-port input stage. The accept decision is made when the strobe is
  // sampled, so a pending write never collides with a clear sweep: a strobe
  // accepted in IDLE lands on the edge where CLEAR is entered at the latest.
  // A clear request in the same cycle beats the strobe.
  // ---------------------------------------------------------------------
  assign in_range  = ({1'b0, x_in} < H_LIM) && ({1'b0, y_in} < V_LIM);
  assign accept_wr = in_range && (state == IDLE) && !clear_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ok_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      drop    <= 1'b0;
    end else begin
      wr_ok_q <= writeEN && accept_wr;
      drop    <= writeEN && !accept_wr;
      x_q     <= x_in;
      y_q     <= y_in;
      c_q     <= c_in;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM: one write of the latched colour per cycle in CLEAR.
  // Further clear requests during a sweep are simply not looked at.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      clr_addr    <= '0;
      clr_color_q <= '0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            clr_color_q <= clear_color;
            busy        <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 17'd1;
          end
        end
      endcase
    end
  end

  // Single write port shared between the sweep and pixel writes.
  always_comb begin
    mem_we  = 1'b0;
    wr_addr = 17'(y_q) * H_MUL + 17'(x_q);
    wr_data = c_q;
    if (state == CLEAR) begin
      mem_we  = 1'b1;
      wr_addr = clr_addr;
      wr_data = clr_color_q;
    end else if (wr_ok_q) begin
      mem_we = 1'b1;
    end
  end

  // Framebuffer storage is never reset; a same-address read returns old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
    rd_data <= mem[rd_addr[AW-1:0]];
  end

  // ---------------------------------------------------------------------
  // Scanout counters: 25 MHz pixel enable, 800 x 525 total raster.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == 10'd799) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Each framebuffer pixel covers a 2x2 block of screen pixels. Screen
  // positions beyond the framebuffer show black (only possible when the
  // framebuffer is smaller than 320x240).
  assign h_half  = h_cnt[9:1];
  assign v_half  = v_cnt[9:1];
  assign in_fb   = ({1'b0, h_half} < H_LIM) && (v_half < V_LIM);
  assign rd_addr = in_fb ? (17'(v_half) * H_MUL + 17'(h_half)) : 17'd0;

  // Stage 1 aligns the timing signals with the registered memory read;
  // stage 2 produces the outputs, 2 clk after the counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_s1       <= 1'b1;
      vs_s1       <= 1'b1;
      blank_s1    <= 1'b0;
      fb_s1       <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_c       <= 3'b000;
    end else begin
      hs_s1       <= !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
      vs_s1       <= !((v_cnt == 10'd490) || (v_cnt == 10'd491));
      blank_s1    <= (h_cnt < 10'd640) && (v_cnt < 10'd480);
      fb_s1       <= in_fb;
      vga_hs      <= hs_s1;
      vga_vs      <= vs_s1;
      vga_blank_n <= blank_s1;
      vga_c       <= (blank_s1 && fb_s1) ? rd_data : 3'b000;
    end
  end

endmodule

// File: tb/tb_frame_sink.sv
// tb/tb_frame_sink.sv - self-checking bench for frame_sink
module tb_frame_sink;

  localparam int H     = 32;
  localparam int V     = 16;
  localparam int DEPTH = H * V;
  localparam int LINE  = 1600;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       writeEN = 1'b0;
  logic [8:0] x_in = '0;
  logic [7:0] y_in = '0;
  logic [2:0] c_in = '0;
  logic       clear_req = 1'b0;
  logic [2:0] clear_color = '0;
  logic       busy, clear_done, drop, vga_hs, vga_vs, vga_blank_n;
  logic [2:0] vga_c;

  int compared = 0;
  int mismatched = 0;
  int n = 0;
  logic [2:0] model [DEPTH];

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       d;
  } wvec_t;

  wvec_t tbl [8];

  frame_sink #(.H_PIX(H), .V_PIX(V)) dut (
    .clk(clk), .resetn(resetn), .writeEN(writeEN), .x_in(x_in), .y_in(y_in),
    .c_in(c_in), .clear_req(clear_req), .clear_color(clear_color), .busy(busy),
    .clear_done(clear_done), .drop(drop), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_c(vga_c)
  );

  always #10 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk) begin
    if (!resetn) n = 0;
    else n = n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Outputs after edge n show the raster position reached after edge n-2;
  // the raster advances one pixel every two edges.
  task automatic scan(input int n_from, input int n_to);
    int ht, h, v, hs_low, blank_hi;
    logic e_hs, e_vs, e_bl;
    logic [2:0] e_c;
    logic [5:0] exp_v, act_v;
    hs_low = 0;
    blank_hi = 0;
    while (n < n_from) @(negedge clk);
    while (n < n_to) begin
      ht = (n - 2) / 2;
      h = ht % 800;
      v = (ht / 800) % 525;
      e_hs = !(h >= 656 && h <= 751);
      e_vs = !(v == 490 || v == 491);
      e_bl = (h < 640) && (v < 480);
      e_c = (e_bl && (h / 2) < H && (v / 2) < V) ? model[(v / 2) * H + h / 2] : 3'b000;
      exp_v = {e_hs, e_vs, e_bl, e_c};
      act_v = {vga_hs, vga_vs, vga_blank_n, vga_c};
      compared++;
      if (act_v != exp_v) begin
        mismatched++;
        $display("FAIL scan n=%0d h=%0d v=%0d: got %b, expected %b", n, h, v, act_v, exp_v);
      end
      if (n < n_from + LINE) begin
        if (!vga_hs) hs_low++;
        if (vga_blank_n) blank_hi++;
      end
      @(negedge clk);
    end
    chk("hs_low_per_line", hs_low, 192);
    chk("blank_high_per_line", blank_hi, 1280);
  endtask

  // Starts a clear at the current negedge and follows it to completion.
  // With stim set, a write accompanies the request, writes are strobed
  // during the sweep and a second request is issued mid-sweep.
  task automatic run_clear(input logic [2:0] col, input bit stim);
    int busy_cnt;
    bit ended;
    logic exp_drop;
    busy_cnt = 0;
    ended = 0;
    clear_req = 1'b1;
    clear_color = col;
    writeEN = stim;
    x_in = 9'd1;
    y_in = 8'd1;
    c_in = 3'd7;
    exp_drop = stim;
    for (int k = 1; k <= DEPTH + 50 && !ended; k++) begin
      @(negedge clk);
      chk("drop_in_clear", drop, exp_drop);
      if (busy) begin
        busy_cnt++;
        clear_req = stim && (k == 100);
        clear_color = 3'b101;
        writeEN = stim && (k % 37 == 5);
        x_in = 9'(k % H);
        y_in = 8'(k % V);
        exp_drop = writeEN;
      end else begin
        ended = 1;
        chk("clear_done_pulse", clear_done, 1);
        clear_req = 1'b0;
        writeEN = 1'b0;
      end
    end
    if (!ended) chk("clear_timeout", 0, 1);
    chk("busy_cycles", busy_cnt, DEPTH);
    @(negedge clk);
    chk("clear_done_width", clear_done, 0);
    chk("drop_after_clear", drop, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = col;
  endtask

  initial begin
    int rx, ry, rc;
    logic exp_drop;
    bit seen;

    tbl[0] = '{9'd10,  8'd5,   3'b101, 1'b0};
    tbl[1] = '{9'd31,  8'd15,  3'b111, 1'b0};
    tbl[2] = '{9'd32,  8'd15,  3'b001, 1'b1};
    tbl[3] = '{9'd0,   8'd16,  3'b001, 1'b1};
    tbl[4] = '{9'd511, 8'd255, 3'b110, 1'b1};
    tbl[5] = '{9'd0,   8'd0,   3'b011, 1'b0};
    tbl[6] = '{9'd11,  8'd5,   3'b000, 1'b0};
    tbl[7] = '{9'd10,  8'd6,   3'b110, 1'b0};

    for (int i = 0; i < DEPTH; i++) model[i] = 3'b000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_drop", drop, 0);
    chk("rst_vga", {vga_hs, vga_vs, vga_blank_n, vga_c}, 6'b110000);

    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_clear(3'b010, 1'b1);

    // Table-driven single writes with drop expectations.
    for (int i = 0; i < 8; i++) begin
      writeEN = 1'b1;
      x_in = tbl[i].x;
      y_in = tbl[i].y;
      c_in = tbl[i].c;
      @(negedge clk);
      writeEN = 1'b0;
      chk($sformatf("tbl_drop_%0d", i), drop, tbl[i].d);
      if (!tbl[i].d) model[tbl[i].y * H + tbl[i].x] = tbl[i].c;
      @(negedge clk);
      chk($sformatf("tbl_drop_width_%0d", i), drop, 0);
    end

    // Back-to-back random writes, some outside the framebuffer.
    exp_drop = 1'b0;
    for (int k = 0; k <= 120; k++) begin
      @(negedge clk);
      if (k > 0) chk("rand_drop", drop, exp_drop);
      if (k < 120) begin
        rx = $urandom_range(0, 35);
        ry = $urandom_range(0, 17);
        rc = $urandom_range(0, 7);
        writeEN = 1'b1;
        x_in = 9'(rx);
        y_in = 8'(ry);
        c_in = 3'(rc);
        exp_drop = (rx >= H) || (ry >= V);
        if (!exp_drop) model[ry * H + rx] = 3'(rc);
      end else begin
        writeEN = 1'b0;
      end
    end

    // Scanout of lines 2..33: framebuffer rows 1..15 plus black lines below.
    scan(2 * LINE, 34 * LINE);

    // Abort a sweep with an asynchronous reset in the middle of a visible line.
    @(negedge clk);
    clear_req = 1'b1;
    clear_color = 3'b100;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (99) @(negedge clk);
    chk("busy_mid_sweep", busy, 1);
    chk("blank_before_reset", vga_blank_n, 1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_clear_done", clear_done, 0);
    chk("arst_drop", drop, 0);
    chk("arst_vga", {vga_hs, vga_vs, vga_blank_n, vga_c}, 6'b110000);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (clear_done || busy) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);

    run_clear(3'b100, 1'b0);
    scan(LINE, 5 * LINE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_sink.md
FRAME_SINK -- requirements
Module: frame_sink

Interface
REQ-001 Parameter H_PIX, default 320: framebuffer width in pixels.
REQ-002 Parameter V_PIX, default 240: framebuffer height in pixels.
REQ-003 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 writeEN  input  1  pixel write strobe from draw/erase controllers; one pixel per cycle when high.
REQ-006 x_in  input  9  pixel column.
REQ-007 y_in  input  8  pixel row.
REQ-008 c_in  input  3  pixel colour, {R,G,B}.
REQ-009 clear_req  input  1  request to fill the whole framebuffer with clear_color.
REQ-010 clear_color  input  3  fill colour, sampled on clear acceptance.
REQ-011 busy  output  1  high while a clear sweep runs.
REQ-012 clear_done  output  1  one-cycle pulse when a clear sweep finishes.
REQ-013 drop  output  1  one-cycle pulse when a write strobe is discarded.
REQ-014 vga_hs  output  1  horizontal sync, active low.
REQ-015 vga_vs  output  1  vertical sync, active low.
REQ-016 vga_blank_n  output  1  high during the visible area.
REQ-017 vga_c  output  3  scanout colour; 3'b000 when vga_blank_n is low.

Function
REQ-018 Framebuffer: H_PIX*V_PIX x 3-bit storage; address = y*H_PIX + x, 17 bits; one write port, one read port; contents are not reset.
REQ-019 Write path: writeEN, x_in, y_in and c_in registered once; memory write in the following cycle; latency 2 clk from strobe to stored.
REQ-020 Range check: strobe with x_in >= H_PIX or y_in >= V_PIX not written; drop pulses 1 clk in the cycle after the strobe.
REQ-021 Control FSM states IDLE and CLEAR; IDLE -> CLEAR on clear_req; CLEAR -> IDLE after the write to the last address.
REQ-022 CLEAR: address counter 0..H_PIX*V_PIX-1, one write of latched clear_color per clk; busy=1 for exactly 76800 cycles at default parameters.
REQ-023 clear_done pulses in the first IDLE cycle after CLEAR.
REQ-024 Strobes during CLEAR are not written; each pulses drop.
REQ-025 clear_req while in CLEAR is ignored; no restart, no queueing.
REQ-026 Simultaneous clear_req and valid writeEN in IDLE: clear wins; the write is dropped and pulses drop.
REQ-027 Scanout timing: pixel enable toggles every clk (25 MHz); h_cnt 0..799 advances on the enable; v_cnt 0..524 advances on h_cnt wrap.
REQ-028 Horizontal timing: visible 0..639; hs low for h_cnt 656..751.
REQ-029 Vertical timing: visible 0..479; vs low for v_cnt 490..491.
REQ-030 Scanout pixel doubling: read address = (v_cnt>>1)*H_PIX + (h_cnt>>1).
REQ-031 Scanout pipeline: vga_hs, vga_vs, vga_blank_n and vga_c all registered with equal delay, 2 clk after the counters.
REQ-032 Scanout runs continuously, independent of the FSM; pixels written during scanout appear no later than the next frame.
REQ-033 Read and write to the same address in the same cycle may return old data; no corruption of either port.

Reset
REQ-034 Assertion of resetn asynchronously forces: state IDLE, h_cnt=v_cnt=0, clear counter 0, input registers cleared, busy=0, clear_done=0, drop=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_c=000.
REQ-035 Reset during CLEAR aborts the sweep; memory is left partially filled; no clear_done pulse.
REQ-036 After deassertion, scanout starts at h_cnt=0, v_cnt=0.

Verification
REQ-037 Reset: assert resetn=0 mid-line -> busy=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_c=000 immediately.
REQ-038 Pixel write: clear to 000, then write x=10, y=5, c=101 -> vga_c=101 for h_cnt 20..21 on v_cnt 10..11; 000 at neighbouring pixels.
REQ-039 Range boundary: write x=319, y=239, c=111 -> stored, shown at h=638..639, v=478..479, no drop; write x=320 -> drop pulse, no memory change.
REQ-040 Clear: clear_req with clear_color=010 -> busy high for exactly 76800 clk, then one clear_done pulse; whole frame shows 010; writes during the sweep each pulse drop; a second clear_req mid-sweep does not extend busy.
REQ-041 Sync timing: vga_hs low for 192 clk in every 1600 clk; vga_vs low for 3200 clk in every 840000 clk; vga_blank_n high for 1280 clk per visible line.
REQ-042 Reset mid-clear at count 1000 -> busy=0 asynchronously, no clear_done, FSM in IDLE; a following clear_req restarts the sweep at address 0.
